// File: rtl/qtable_loader_if.sv
// rtl/qtable_loader_if.sv - DQT payload byte stream between a byte source and the quantization table loader
interface qtable_loader_if;
    logic [7:0] dqt_data;
    logic       dqt_valid;
    logic       dqt_ready;

    modport master (output dqt_data, output dqt_valid, input dqt_ready);
    modport slave  (input dqt_data, input dqt_valid, output dqt_ready);
endinterface

// File: rtl/qtable_loader.sv
// rtl/qtable_loader.sv - DQT segment parser writing de-zigzagged 64-entry tables into lum/chr memories
module qtable_loader #(
    parameter logic [3:0] LUM_TQ = 4'd0,
    parameter logic [3:0] CHR_TQ = 4'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          seg_len,
    qtable_loader_if.slave       dqt,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 lum_qtable_wr_ext,
    output logic                 chr_qtable_wr_ext,
    output logic [5:0]           lum_qtable_addr_ext,
    output logic [5:0]           chr_qtable_addr_ext,
    output logic [7:0]           lum_qtable_wdata_ext,
    output logic [7:0]           chr_qtable_wdata_ext
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, ERR} state_t;

    // Position k in the zigzag stream lands at natural (row-major) address ZZ[k].
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t      state;
    logic [15:0] rem;
    logic [5:0]  k;
    logic        sel_chr;
    logic        accept;
    logic        hdr_ok;

    // A header is only taken when a whole table (Pq/Tq byte + 64 entries) remains.
    assign dqt.dqt_ready = (state == DATA) || ((state == HDR) && (rem >= 16'd65));
    assign busy          = (state == HDR) || (state == DATA);
    assign accept        = dqt.dqt_valid && dqt.dqt_ready;
    assign hdr_ok        = (dqt.dqt_data[7:4] == 4'd0) &&
                           ((dqt.dqt_data[3:0] == LUM_TQ) || (dqt.dqt_data[3:0] == CHR_TQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            rem                  <= 16'd0;
            k                    <= 6'd0;
            sel_chr              <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            lum_qtable_wr_ext    <= 1'b0;
            chr_qtable_wr_ext    <= 1'b0;
            lum_qtable_addr_ext  <= 6'd0;
            chr_qtable_addr_ext  <= 6'd0;
            lum_qtable_wdata_ext <= 8'd0;
            chr_qtable_wdata_ext <= 8'd0;
        end else begin
            done              <= 1'b0;
            lum_qtable_wr_ext <= 1'b0;
            chr_qtable_wr_ext <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= (seg_len < 16'd2);
                        rem <= seg_len - 16'd2;
                        state <= (seg_len < 16'd2) ? ERR : HDR;
                    end
                end
                HDR: begin
                    if (rem == 16'd0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (rem < 16'd65) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else if (accept) begin
                        if (hdr_ok) begin
                            sel_chr <= (dqt.dqt_data[3:0] == CHR_TQ);
                            k       <= 6'd0;
                            rem     <= rem - 16'd1;
                            state   <= DATA;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        rem <= rem - 16'd1;
                        k   <= k + 6'd1;
                        if (sel_chr) begin
                            chr_qtable_wr_ext    <= 1'b1;
                            chr_qtable_addr_ext  <= ZZ[k];
                            chr_qtable_wdata_ext <= dqt.dqt_data;
                        end else begin
                            lum_qtable_wr_ext    <= 1'b1;
                            lum_qtable_addr_ext  <= ZZ[k];
                            lum_qtable_wdata_ext <= dqt.dqt_data;
                        end
                        if (k == 6'd63) begin
                            state <= HDR;
                        end
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtable_loader.sv
// tb/tb_qtable_loader.sv - directed self-checking bench for qtable_loader
module tb_qtable_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seg_len;
    logic        busy, done, err;
    logic        lum_wr, chr_wr;
    logic [5:0]  lum_addr, chr_addr;
    logic [7:0]  lum_wdata, chr_wdata;

    qtable_loader_if bus ();

    qtable_loader #(.LUM_TQ(4'd0), .CHR_TQ(4'd1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .seg_len              (seg_len),
        .dqt                  (bus),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .lum_qtable_wr_ext    (lum_wr),
        .chr_qtable_wr_ext    (chr_wr),
        .lum_qtable_addr_ext  (lum_addr),
        .chr_qtable_addr_ext  (chr_addr),
        .lum_qtable_wdata_ext (lum_wdata),
        .chr_qtable_wdata_ext (chr_wdata)
    );

    always #5 clk = ~clk;

    int zz [64] = '{
        0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,
        21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,
        60,61,54,47,55,62,63
    };

    int tests = 0;
    int fails = 0;
    int timeouts = 0;

    int         lum_cnt, chr_cnt, done_cnt;
    logic [5:0] lum_seq_a [128];
    logic [7:0] lum_seq_d [128];
    logic [5:0] chr_seq_a [128];
    logic [7:0] chr_seq_d [128];

    always @(negedge clk) begin
        if (lum_wr === 1'b1) begin
            if (lum_cnt < 128) begin
                lum_seq_a[lum_cnt] = lum_addr;
                lum_seq_d[lum_cnt] = lum_wdata;
            end
            lum_cnt++;
        end
        if (chr_wr === 1'b1) begin
            if (chr_cnt < 128) begin
                chr_seq_a[chr_cnt] = chr_addr;
                chr_seq_d[chr_cnt] = chr_wdata;
            end
            chr_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        lum_cnt = 0;
        chr_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] len);
        start = 1'b1;
        seg_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.dqt_data = b;
        bus.dqt_valid = 1'b1;
        while (bus.dqt_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeouts++;
        @(negedge clk);
        bus.dqt_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        seg_len = 16'd0;
        bus.dqt_data = 8'd0;
        bus.dqt_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, err, bus.dqt_ready, lum_wr, chr_wr} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got %b expected 000000", {busy, done, err, bus.dqt_ready, lum_wr, chr_wr});
        end
        tests++;
        if ({lum_addr, chr_addr, lum_wdata, chr_wdata} !== 28'd0) begin
            fails++;
            $display("FAIL reset_bus got %h expected 0", {lum_addr, chr_addr, lum_wdata, chr_wdata});
        end
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
    endtask

    task automatic test_single_lum();
        clear_mon();
        do_start(16'd67);
        send_byte(8'h00);
        for (int i = 1; i <= 64; i++) send_byte(8'(i));
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL lum_done_early got %b expected 0", done); end
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL lum_done_pulse got %b expected 1", done); end
        @(negedge clk);
        tests++;
        if ({done, busy, err} !== 3'b000) begin fails++; $display("FAIL lum_after got %b expected 000", {done, busy, err}); end
        repeat (2) @(negedge clk);
        tests++;
        if (lum_cnt !== 64 || chr_cnt !== 0 || done_cnt !== 1) begin
            fails++;
            $display("FAIL lum_counts got lum=%0d chr=%0d done=%0d expected 64 0 1", lum_cnt, chr_cnt, done_cnt);
        end
        tests++;
        if (lum_seq_a[2] !== 6'd8 || lum_seq_a[3] !== 6'd16) begin
            fails++;
            $display("FAIL lum_k2_k3_addr got %0d %0d expected 8 16", lum_seq_a[2], lum_seq_a[3]);
        end
        tests++;
        if (lum_seq_a[63] !== 6'd63 || lum_seq_d[63] !== 8'd64) begin
            fails++;
            $display("FAIL lum_k63 got addr %0d data %0d expected 63 64", lum_seq_a[63], lum_seq_d[63]);
        end
        for (int k = 0; k < 64; k++) begin
            tests++;
            if (lum_seq_a[k] !== 6'(zz[k]) || lum_seq_d[k] !== 8'(k + 1)) begin
                fails++;
                $display("FAIL lum_entry k=%0d got addr %0d data %0d expected %0d %0d", k, lum_seq_a[k], lum_seq_d[k], zz[k], k + 1);
            end
        end
    endtask

    task automatic test_two_tables();
        clear_mon();
        do_start(16'd132);
        send_byte(8'h00);
        for (int i = 1; i <= 64; i++) send_byte(8'(i));
        send_byte(8'h01);
        for (int i = 1; i <= 63; i++) send_byte(8'(i + 64));
        tests++;
        if (done_cnt !== 0) begin fails++; $display("FAIL two_done_early got %0d expected 0", done_cnt); end
        send_byte(8'd128);
        @(negedge clk);
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL two_done_pulse got %b expected 1", done); end
        repeat (3) @(negedge clk);
        tests++;
        if (lum_cnt !== 64 || chr_cnt !== 64 || done_cnt !== 1) begin
            fails++;
            $display("FAIL two_counts got lum=%0d chr=%0d done=%0d expected 64 64 1", lum_cnt, chr_cnt, done_cnt);
        end
        tests++;
        if (chr_seq_a[0] !== 6'd0 || chr_seq_d[0] !== 8'd65 || chr_seq_a[63] !== 6'd63 || chr_seq_d[63] !== 8'd128) begin
            fails++;
            $display("FAIL two_chr_ends got %0d/%0d %0d/%0d expected 0/65 63/128", chr_seq_a[0], chr_seq_d[0], chr_seq_a[63], chr_seq_d[63]);
        end
        tests++;
        if (lum_seq_a[4] !== 6'd9 || lum_seq_d[4] !== 8'd5) begin
            fails++;
            $display("FAIL two_lum_k4 got %0d/%0d expected 9/5", lum_seq_a[4], lum_seq_d[4]);
        end
    endtask

    task automatic test_bad_header();
        clear_mon();
        do_start(16'd67);
        send_byte(8'h10);
        tests++;
        if ({err, bus.dqt_ready, busy} !== 3'b100) begin
            fails++;
            $display("FAIL bad_pq got err/ready/busy %b expected 100", {err, bus.dqt_ready, busy});
        end
        @(negedge clk);
        tests++;
        if ({err, busy} !== 2'b10) begin fails++; $display("FAIL bad_pq_held got %b expected 10", {err, busy}); end
        do_start(16'd67);
        tests++;
        if ({err, busy} !== 2'b01) begin fails++; $display("FAIL start_clears_err got %b expected 01", {err, busy}); end
        send_byte(8'h05);
        tests++;
        if ({err, bus.dqt_ready} !== 2'b10) begin fails++; $display("FAIL bad_tq got %b expected 10", {err, bus.dqt_ready}); end
        @(negedge clk);
        do_start(16'd67);
        send_byte(8'h01);
        for (int i = 0; i < 64; i++) send_byte(8'(200 - i));
        repeat (3) @(negedge clk);
        tests++;
        if (lum_cnt !== 0 || chr_cnt !== 64 || done_cnt !== 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL bad_recover got lum=%0d chr=%0d done=%0d err=%b expected 0 64 1 0", lum_cnt, chr_cnt, done_cnt, err);
        end
        tests++;
        if (chr_seq_a[5] !== 6'd2 || chr_seq_d[5] !== 8'd195) begin
            fails++;
            $display("FAIL bad_recover_k5 got %0d/%0d expected 2/195", chr_seq_a[5], chr_seq_d[5]);
        end
    endtask

    task automatic test_length();
        int rdy;
        clear_mon();
        rdy = 0;
        bus.dqt_data = 8'h00;
        bus.dqt_valid = 1'b1;
        do_start(16'd40);
        repeat (3) begin
            if (bus.dqt_ready === 1'b1) rdy++;
            @(negedge clk);
        end
        bus.dqt_valid = 1'b0;
        tests++;
        if (rdy !== 0) begin fails++; $display("FAIL len40_ready got %0d cycles expected 0", rdy); end
        tests++;
        if ({err, busy} !== 2'b10) begin fails++; $display("FAIL len40_err got %b expected 10", {err, busy}); end
        do_start(16'd2);
        tests++;
        if ({err, busy} !== 2'b01) begin fails++; $display("FAIL len2_hdr got %b expected 01", {err, busy}); end
        @(negedge clk);
        tests++;
        if ({done, busy, err} !== 3'b100) begin fails++; $display("FAIL len2_done got %b expected 100", {done, busy, err}); end
        do_start(16'd1);
        tests++;
        if ({err, busy} !== 2'b10) begin fails++; $display("FAIL len1_err got %b expected 10", {err, busy}); end
        @(negedge clk);
        tests++;
        if (lum_cnt !== 0 || chr_cnt !== 0 || done_cnt !== 1) begin
            fails++;
            $display("FAIL len_writes got lum=%0d chr=%0d done=%0d expected 0 0 1", lum_cnt, chr_cnt, done_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        int gap;
        logic [7:0] b;
        clear_mon();
        do_start(16'd67);
        send_byte(8'h00);
        for (int k = 0; k < 64; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                tests++;
                if (lum_wr !== 1'b0) begin fails++; $display("FAIL gap_no_write k=%0d got %b expected 0", k, lum_wr); end
            end
            tests++;
            if (bus.dqt_ready !== 1'b1) begin fails++; $display("FAIL gap_ready k=%0d got %b expected 1", k, bus.dqt_ready); end
            b = 8'(k) ^ 8'hA5;
            bus.dqt_data = b;
            bus.dqt_valid = 1'b1;
            @(negedge clk);
            bus.dqt_valid = 1'b0;
            tests++;
            if (lum_wr !== 1'b1 || lum_addr !== 6'(zz[k]) || lum_wdata !== b) begin
                fails++;
                $display("FAIL gap_write k=%0d got wr=%b addr=%0d data=%h expected 1 %0d %h", k, lum_wr, lum_addr, lum_wdata, zz[k], b);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (lum_cnt !== 64 || chr_cnt !== 0 || done_cnt !== 1) begin
            fails++;
            $display("FAIL gap_counts got lum=%0d chr=%0d done=%0d expected 64 0 1", lum_cnt, chr_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        do_start(16'd67);
        send_byte(8'h00);
        for (int k = 0; k < 30; k++) send_byte(8'(k + 1));
        bus.dqt_data = 8'd31;
        bus.dqt_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dqt_valid = 1'b0;
        tests++;
        if ({busy, done, err, bus.dqt_ready, lum_wr, chr_wr} !== 6'b0 || {lum_addr, lum_wdata} !== 14'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs got %b %h expected all 0", {busy, done, err, bus.dqt_ready, lum_wr, chr_wr}, {lum_addr, lum_wdata});
        end
        @(negedge clk);
        tests++;
        if (lum_cnt !== 30 || done_cnt !== 0) begin
            fails++;
            $display("FAIL rst_mid_dropped got lum=%0d done=%0d expected 30 0", lum_cnt, done_cnt);
        end
        clear_mon();
        do_start(16'd67);
        send_byte(8'h00);
        for (int i = 1; i <= 64; i++) send_byte(8'(i + 10));
        repeat (3) @(negedge clk);
        tests++;
        if (lum_cnt !== 64 || done_cnt !== 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_reload got lum=%0d done=%0d err=%b expected 64 1 0", lum_cnt, done_cnt, err);
        end
        tests++;
        if (lum_seq_a[10] !== 6'd32 || lum_seq_d[10] !== 8'd21) begin
            fails++;
            $display("FAIL rst_mid_k10 got %0d/%0d expected 32/21", lum_seq_a[10], lum_seq_d[10]);
        end
    endtask

    initial begin
        clear_mon();
        @(negedge clk);
        test_reset();
        test_single_lum();
        test_two_tables();
        test_bad_header();
        test_length();
        test_valid_gaps();
        test_reset_mid();
        tests++;
        if (timeouts !== 0) begin fails++; $display("FAIL ready_timeouts got %0d expected 0", timeouts); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
